// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encodings and default widths for the PWM break block
package pwm_pkg;

  localparam int NUM_OUT_DEF = 4;
  localparam int FLT_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BREAK   = 2'd2,
    ST_WAIT_UE = 2'd3
  } brk_state_e;

endpackage

// File: rtl/pwm_brk_filter.sv
// rtl/pwm_brk_filter.sv - break pin polarity, 2-flop synchronizer and consecutive-sample filter
module pwm_brk_filter #(
  parameter int FLT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             brk_pin,
  input  logic             brk_pol,
  input  logic             brk_en,
  input  logic [FLT_W-1:0] flt_len,
  output logic             brk_s,
  output logic             trip
);

  logic             brk_meta;
  logic [FLT_W-1:0] cnt;
  logic             brk_act;

  // Polarity is folded in before the synchronizer so both flops carry the active level.
  assign brk_act = brk_pin ^ brk_pol;

  // Two-flop synchronizer for the asynchronous fault pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_meta <= 1'b0;
      brk_s    <= 1'b0;
    end else begin
      brk_meta <= brk_act;
      brk_s    <= brk_meta;
    end
  end

  // Count consecutive active samples; saturate at all-ones, drop to zero on any inactive sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (brk_s && brk_en) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Trip fires on the sample after flt_len extra active samples have been seen.
  assign trip = brk_s && brk_en && (cnt == flt_len);

endmodule

// File: rtl/pwm_break.sv
// rtl/pwm_break.sv - PWM output gating with break input FSM; optional shoot-through guard via PWM_BREAK_SHOOT_GUARD_EN
module pwm_break
  import pwm_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int FLT_W   = FLT_W_DEF
) (
  input  logic               clk_psc_i,
  input  logic               rst_i,
  input  logic [NUM_OUT-1:0] pwm_i,
  input  logic               update_event_i,
  input  logic               moe_i,
  input  logic               brk_i,
  input  logic               brk_en_i,
  input  logic               brk_pol_i,
  input  logic [FLT_W-1:0]   flt_len_i,
  input  logic [NUM_OUT-1:0] safe_lvl_i,
  input  logic               auto_rearm_i,
  input  logic               clr_i,
  output logic [NUM_OUT-1:0] pwm_o,
  output logic               brk_flag_o,
  output logic [1:0]         state_o
`ifdef PWM_BREAK_SHOOT_GUARD_EN
  ,
  output logic               xguard_flag_o
`endif
);

  brk_state_e         state;
  brk_state_e         nxt;
  logic               brk_s;
  logic               trip;
  logic [NUM_OUT-1:0] run_val;
  logic               shoot;

  pwm_brk_filter #(.FLT_W(FLT_W)) u_filter (
    .clk     (clk_psc_i),
    .rst     (rst_i),
    .brk_pin (brk_i),
    .brk_pol (brk_pol_i),
    .brk_en  (brk_en_i),
    .flt_len (flt_len_i),
    .brk_s   (brk_s),
    .trip    (trip)
  );

  // Value driven while running; the guard replaces both legs of a pair that would conduct together.
  always_comb begin
    run_val = pwm_i;
    shoot   = 1'b0;
`ifdef PWM_BREAK_SHOOT_GUARD_EN
    for (int k = 0; k < NUM_OUT / 2; k++) begin
      if (pwm_i[2*k] && pwm_i[2*k+1]) begin
        run_val[2*k]   = safe_lvl_i[2*k];
        run_val[2*k+1] = safe_lvl_i[2*k+1];
        shoot          = 1'b1;
      end
    end
`endif
  end

  // Next-state selection; a trip overrides every other request from any state.
  always_comb begin
    nxt = state;
    if (trip) begin
      nxt = ST_BREAK;
    end else begin
      case (state)
        ST_IDLE:    if (update_event_i && moe_i) nxt = ST_RUN;
        ST_RUN:     if (!moe_i) nxt = ST_IDLE;
        ST_BREAK:   if (!brk_s && (clr_i || auto_rearm_i)) nxt = ST_WAIT_UE;
        ST_WAIT_UE: begin
          if (!moe_i) nxt = ST_IDLE;
          else if (update_event_i) nxt = ST_RUN;
        end
        default:    nxt = ST_IDLE;
      endcase
    end
  end

  // State, gated outputs and sticky flags; outputs follow the state being entered so a trip gates immediately.
  always_ff @(posedge clk_psc_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      pwm_o      <= '0;
      brk_flag_o <= 1'b0;
    end else begin
      state <= nxt;
      pwm_o <= (nxt == ST_RUN) ? run_val : safe_lvl_i;
      if (trip) brk_flag_o <= 1'b1;
      else if (clr_i && !brk_s) brk_flag_o <= 1'b0;
    end
  end

`ifdef PWM_BREAK_SHOOT_GUARD_EN
  // Sticky record of any guarded cycle; a new event wins over a simultaneous clear.
  always_ff @(posedge clk_psc_i or posedge rst_i) begin
    if (rst_i) xguard_flag_o <= 1'b0;
    else if ((nxt == ST_RUN) && shoot) xguard_flag_o <= 1'b1;
    else if (clr_i) xguard_flag_o <= 1'b0;
  end
`else
  logic unused_shoot;
  assign unused_shoot = shoot;
`endif

  assign state_o = state;

endmodule

// File: tb/tb_pwm_break.sv
// tb/tb_pwm_break.sv - scoreboard bench for pwm_break
module tb_pwm_break;

  logic       clk_psc_i = 1'b0;
  logic       rst_i;
  logic [3:0] pwm_i;
  logic       update_event_i;
  logic       moe_i;
  logic       brk_i;
  logic       brk_en_i;
  logic       brk_pol_i;
  logic [3:0] flt_len_i;
  logic [3:0] safe_lvl_i;
  logic       auto_rearm_i;
  logic       clr_i;
  logic [3:0] pwm_o;
  logic       brk_flag_o;
  logic [1:0] state_o;
`ifdef PWM_BREAK_SHOOT_GUARD_EN
  logic       xguard_flag_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  always #5 clk_psc_i = ~clk_psc_i;

  pwm_break dut (
    .clk_psc_i      (clk_psc_i),
    .rst_i          (rst_i),
    .pwm_i          (pwm_i),
    .update_event_i (update_event_i),
    .moe_i          (moe_i),
    .brk_i          (brk_i),
    .brk_en_i       (brk_en_i),
    .brk_pol_i      (brk_pol_i),
    .flt_len_i      (flt_len_i),
    .safe_lvl_i     (safe_lvl_i),
    .auto_rearm_i   (auto_rearm_i),
    .clr_i          (clr_i),
    .pwm_o          (pwm_o),
    .brk_flag_o     (brk_flag_o),
    .state_o        (state_o)
`ifdef PWM_BREAK_SHOOT_GUARD_EN
    ,
    .xguard_flag_o  (xguard_flag_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] run_model(input logic [3:0] p, input logic [3:0] s);
    logic [3:0] r;
    r = p;
`ifdef PWM_BREAK_SHOOT_GUARD_EN
    if (p[0] && p[1]) begin r[0] = s[0]; r[1] = s[1]; end
    if (p[2] && p[3]) begin r[2] = s[2]; r[3] = s[3]; end
`else
    if (s === 4'hx) r = 4'hx;
`endif
    return r;
  endfunction

  // One clock: drive pwm_i, queue the expected pwm_o, advance, then pop and compare.
  task automatic cyc(input logic [3:0] p, input bit run);
    logic [3:0] e;
    pwm_i = p;
    exp_q.push_back(run ? run_model(p, safe_lvl_i) : safe_lvl_i);
    @(posedge clk_psc_i);
    #1;
    e = exp_q.pop_front();
    check("pwm_o", {28'd0, pwm_o}, {28'd0, e});
  endtask

  task automatic rcyc(input bit run);
    logic [3:0] p;
    p = 4'($urandom_range(15));
    cyc(p, run);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] e);
    check(tag, {30'd0, state_o}, {30'd0, e});
  endtask

  initial begin
    rst_i = 1'b1; pwm_i = 4'h0; update_event_i = 1'b0; moe_i = 1'b0;
    brk_i = 1'b0; brk_en_i = 1'b1; brk_pol_i = 1'b0; flt_len_i = 4'd3;
    safe_lvl_i = 4'b1010; auto_rearm_i = 1'b0; clr_i = 1'b0;
    #2;
    chk_state("rst_state", 2'd0);
    check("rst_pwm", {28'd0, pwm_o}, 32'd0);
    check("rst_flag", {31'd0, brk_flag_o}, 32'd0);
    #10;
    rst_i = 1'b0;
    moe_i = 1'b1;

    // Idle for nine cycles, update event on the tenth.
    for (int i = 0; i < 9; i++) begin
      rcyc(1'b0);
      chk_state("idle_state", 2'd0);
    end
    update_event_i = 1'b1;
    rcyc(1'b1);
    update_event_i = 1'b0;
    chk_state("ue_to_run", 2'd1);
    for (int i = 0; i < 8; i++) rcyc(1'b1);

    // Three-cycle glitch with flt_len=3 must not trip.
    brk_i = 1'b1;
    for (int i = 0; i < 3; i++) rcyc(1'b1);
    brk_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rcyc(1'b1);
      chk_state("glitch_run", 2'd1);
    end
    check("glitch_flag", {31'd0, brk_flag_o}, 32'd0);

    // Held fault trips on edge 5.
    brk_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rcyc(k < 5);
      chk_state("trip_state", (k < 5) ? 2'd1 : 2'd2);
    end
    check("trip_flag", {31'd0, brk_flag_o}, 32'd1);

    // Safe level change in BREAK, moe ignored, clear blocked while fault active with filter disabled.
    safe_lvl_i = 4'b0101;
    rcyc(1'b0);
    safe_lvl_i = 4'b1010;
    moe_i = 1'b0;
    rcyc(1'b0);
    chk_state("brk_moe_ign", 2'd2);
    moe_i = 1'b1;
    brk_en_i = 1'b0;
    clr_i = 1'b1;
    rcyc(1'b0);
    chk_state("brk_en_off", 2'd2);
    check("brk_en_flag", {31'd0, brk_flag_o}, 32'd1);
    clr_i = 1'b0;
    brk_en_i = 1'b1;

    // Fault removed, software clear, then update event back to RUN.
    brk_i = 1'b0;
    rcyc(1'b0);
    rcyc(1'b0);
    chk_state("brk_hold", 2'd2);
    clr_i = 1'b1;
    rcyc(1'b0);
    clr_i = 1'b0;
    chk_state("clr_wait_ue", 2'd3);
    check("clr_flag", {31'd0, brk_flag_o}, 32'd0);
    rcyc(1'b0);
    update_event_i = 1'b1;
    rcyc(1'b1);
    update_event_i = 1'b0;
    chk_state("wait_to_run", 2'd1);

    // Trip, clear and update event on the same edge.
    brk_i = 1'b1;
    for (int i = 0; i < 5; i++) rcyc(1'b1);
    clr_i = 1'b1;
    update_event_i = 1'b1;
    rcyc(1'b0);
    update_event_i = 1'b0;
    chk_state("prio_state", 2'd2);
    check("prio_flag", {31'd0, brk_flag_o}, 32'd1);
    rcyc(1'b0);
    check("clr_active_flag", {31'd0, brk_flag_o}, 32'd1);
    clr_i = 1'b0;

    // Active-low pin with auto re-arm.
    brk_pol_i = 1'b1;
    auto_rearm_i = 1'b1;
    rcyc(1'b0);
    rcyc(1'b0);
    chk_state("auto_hold", 2'd2);
    rcyc(1'b0);
    chk_state("auto_wait", 2'd3);
    update_event_i = 1'b1;
    rcyc(1'b1);
    update_event_i = 1'b0;
    chk_state("auto_run", 2'd1);
    brk_i = 1'b0;
    for (int k = 0; k < 6; k++) rcyc(k < 5);
    chk_state("pol_trip", 2'd2);
    brk_i = 1'b1;
    rcyc(1'b0);
    rcyc(1'b0);
    chk_state("pol_hold", 2'd2);
    rcyc(1'b0);
    chk_state("pol_rearm", 2'd3);
    check("rearm_flag", {31'd0, brk_flag_o}, 32'd1);
    auto_rearm_i = 1'b0;

    // Trip from IDLE with zero filter length.
    moe_i = 1'b0;
    rcyc(1'b0);
    chk_state("to_idle", 2'd0);
    flt_len_i = 4'd0;
    brk_i = 1'b0;
    rcyc(1'b0);
    rcyc(1'b0);
    chk_state("idle_pre", 2'd0);
    rcyc(1'b0);
    chk_state("idle_trip", 2'd2);

    // Asynchronous reset mid-BREAK, fault still present re-trips after two edges.
    rst_i = 1'b1;
    #2;
    chk_state("arst_state", 2'd0);
    check("arst_pwm", {28'd0, pwm_o}, 32'd0);
    check("arst_flag", {31'd0, brk_flag_o}, 32'd0);
    rst_i = 1'b0;
    rcyc(1'b0);
    rcyc(1'b0);
    chk_state("retrip_pre", 2'd0);
    rcyc(1'b0);
    chk_state("retrip", 2'd2);

    // Back to RUN for the shoot-through pattern.
    brk_pol_i = 1'b0;
    rcyc(1'b0);
    rcyc(1'b0);
    clr_i = 1'b1;
    rcyc(1'b0);
    clr_i = 1'b0;
    chk_state("g_wait", 2'd3);
    moe_i = 1'b1;
    update_event_i = 1'b1;
    rcyc(1'b1);
    update_event_i = 1'b0;
    chk_state("g_run", 2'd1);
    cyc(4'b0011, 1'b1);
`ifdef PWM_BREAK_SHOOT_GUARD_EN
    check("xguard_set", {31'd0, xguard_flag_o}, 32'd1);
`endif
    cyc(4'b0100, 1'b1);
`ifdef PWM_BREAK_SHOOT_GUARD_EN
    check("xguard_sticky", {31'd0, xguard_flag_o}, 32'd1);
`endif
    clr_i = 1'b1;
    cyc(4'b0100, 1'b1);
    clr_i = 1'b0;
`ifdef PWM_BREAK_SHOOT_GUARD_EN
    check("xguard_clr", {31'd0, xguard_flag_o}, 32'd0);
`endif
    chk_state("g_end", 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
